gbe_cpu_tx_ctrl: RTL and testbench
==================================

Name: gbe_cpu_tx_ctrl

Overview:
- Drains a CPU-written frame from the CPU TX buffer's MAC-side read port.
- Streams the frame as 64-bit words into the UDP/MAC transmit mux.
- Returns the tx-done handshake to the OPB CPU attachment.
- Sits between the dual-port CPU TX buffer / CPU register block and the transmit arbiter; lives entirely in the MAC TX clock domain.

Parameters:
- ADDR_WIDTH, 8, word address width of the TX buffer read port (256 x 64-bit = 2 KB)
- DATA_WIDTH, 64, stream and buffer word width
- SYNC_STAGES, 2, flop stages synchronising cpu_tx_ready into mac_tx_clk

Ports:
- mac_tx_clk  in  1  sole clock
- mac_tx_rst_n  in  1  asynchronous active-low reset
- cpu_tx_size  in  12  frame length in 64-bit words; quasi-static while cpu_tx_ready is high
- cpu_tx_ready  in  1  level from CPU domain; frame loaded and ready to send
- cpu_tx_done  out  1  level; frame sent, held until cpu_tx_ready is seen low
- tx_buffer_addr  out  ADDR_WIDTH  read address
- tx_buffer_rd_data  in  DATA_WIDTH  read data, 1-cycle latency
- tx_req  out  1  request for the transmit mux
- tx_grant  in  1  mux granted; held by the arbiter until tx_eof is accepted
- tx_data  out  DATA_WIDTH  stream data
- tx_valid  out  1  stream valid
- tx_eof  out  1  last word of frame, qualified by tx_valid
- tx_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; address 0; synchroniser cleared.
- ready_s = cpu_tx_ready after SYNC_STAGES flops. Only ready_s is used.
- cpu_tx_size is sampled once, in the IDLE->REQ transition, into len_reg.
  - len_reg = min(cpu_tx_size, 2^ADDR_WIDTH).
- IDLE:
  - ready_s=1 and size!=0 -> REQ.
  - ready_s=1 and size==0 -> DONE, with no request and no stream.
- REQ:
  - tx_req=1; tx_grant=1 -> STREAM.
  - Word 0's read is issued on the grant cycle.
  - tx_valid first rises 2 cycles after tx_grant is first sampled high.
- STREAM:
  - Beat = tx_valid & tx_ready.
  - Sustains 1 beat/cycle while tx_ready=1.
  - Two-entry skid (output reg + one skid reg) absorbs RAM latency; no word is lost or duplicated when tx_ready toggles.
  - While tx_valid & !tx_ready, tx_data and tx_eof hold stable; tx_valid is never withdrawn except by reset.
  - Address increments per issued read and stops at len_reg-1. No wrap, because len_reg <= depth.
  - tx_eof=1 exactly on word len_reg-1.
  - tx_req stays high through the eof beat and drops the cycle after.
  - Eof beat -> DONE.
- DONE:
  - cpu_tx_done=1 from the cycle after the eof beat.
  - Waits for ready_s=0, then deasserts cpu_tx_done -> IDLE. Four-phase handshake.
  - The CPU clears its size/ready on seeing done; that clear is what drops ready_s.
- ready_s falling mid-frame: ignored; the frame completes (no abort).
- tx_grant dropping mid-frame: protocol violation; the block keeps streaming when tx_ready allows.
- Reset mid-frame: stream terminates without eof; the downstream mux must discard on reset.

Optional Feature:
- Macro GBE_CPU_TX_CTRL_FRAME_COUNT_EN.
- Defined: adds output tx_frame_count [31:0].
  - Increments on each eof beat; wraps 0xFFFFFFFF->0.
  - Size-0 completions are not counted.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package gbe_cpu_tx_pkg: state enum (IDLE, REQ, STREAM, DONE), DATA_WIDTH/ADDR_WIDTH defaults, max-frame-words constant.
- One sub-module, gbe_tx_skid: the 2-entry valid/ready skid buffer, with an input port driven by the RAM read pipeline.
- Synchroniser stays inline.

Test Plan:
- size=4, ready=1, tx_grant 3 cycles after tx_req, tx_ready=1 -> words 0..3 on consecutive cycles, valid at grant+2, eof on word 3 only, done the cycle after, done clears after ready deasserts.
- size=8, tx_ready pattern 1,0,0,1,0,1,1,... -> exactly 8 beats, in order, data stable during stalls, single eof.
- size=0, ready=1 -> no tx_req, cpu_tx_done asserts after the synchroniser, clears when ready drops.
- size=0x300 -> 256 beats, eof on address 255, no wrap.
- Async reset asserted mid-frame at beat 5 -> all outputs 0 immediately; with ready held, a fresh frame starts from word 0 after release.
- With GBE_CPU_TX_CTRL_FRAME_COUNT_EN defined: three frames of sizes 1, 2, 0 -> tx_frame_count = 2.

Source files
------------

// File: rtl/gbe_cpu_tx_pkg.sv
// Shared types and defaults for the CPU TX frame drain path (gbe_cpu_tx_ctrl).
package gbe_cpu_tx_pkg;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MAX_FRAME_WORDS = 1 << DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} tx_state_e;
endpackage

// File: rtl/gbe_tx_skid.sv
// Two-entry valid/ready skid (output reg + skid reg) fed by a 1-cycle RAM read pipe.
// The producer must only issue reads it has credit for; occ_o exposes the fill level.
module gbe_tx_skid #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [1:0]            occ_o
);
  logic                  out_v_q, out_v_d, out_l_q, out_l_d;
  logic                  sk_v_q, sk_v_d, sk_l_q, sk_l_d;
  logic [DATA_WIDTH-1:0] out_d_q, out_d_d, sk_d_q, sk_d_d;

  always_comb begin
    out_v_d = out_v_q;
    out_l_d = out_l_q;
    out_d_d = out_d_q;
    sk_v_d  = sk_v_q;
    sk_l_d  = sk_l_q;
    sk_d_d  = sk_d_q;
    if (!out_v_q || out_ready_i) begin
      if (sk_v_q) begin
        out_v_d = 1'b1;
        out_d_d = sk_d_q;
        out_l_d = sk_l_q;
        sk_v_d  = in_valid_i;
        if (in_valid_i) begin
          sk_d_d = in_data_i;
          sk_l_d = in_last_i;
        end
      end else begin
        out_v_d = in_valid_i;
        if (in_valid_i) begin
          out_d_d = in_data_i;
          out_l_d = in_last_i;
        end
      end
    end else if (in_valid_i) begin
      // Output is stalled: park the arriving RAM word.
      sk_v_d = 1'b1;
      sk_d_d = in_data_i;
      sk_l_d = in_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v_q <= 1'b0;
      out_l_q <= 1'b0;
      out_d_q <= '0;
      sk_v_q  <= 1'b0;
      sk_l_q  <= 1'b0;
      sk_d_q  <= '0;
    end else begin
      out_v_q <= out_v_d;
      out_l_q <= out_l_d;
      out_d_q <= out_d_d;
      sk_v_q  <= sk_v_d;
      sk_l_q  <= sk_l_d;
      sk_d_q  <= sk_d_d;
    end
  end

  assign out_valid_o = out_v_q;
  assign out_data_o  = out_d_q;
  assign out_last_o  = out_v_q & out_l_q;
  assign occ_o       = {out_v_q & sk_v_q, out_v_q ^ sk_v_q};
endmodule

// File: rtl/gbe_cpu_tx_ctrl.sv
// Drains a CPU-written frame from the TX buffer into the transmit mux, then does the done handshake.
// Optional GBE_CPU_TX_CTRL_FRAME_COUNT_EN adds a 32-bit count of completed (non-empty) frames.
module gbe_cpu_tx_ctrl
  import gbe_cpu_tx_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  mac_tx_clk,
  input  logic                  mac_tx_rst_n,
  input  logic [11:0]           cpu_tx_size,
  input  logic                  cpu_tx_ready,
  output logic                  cpu_tx_done,
  output logic [ADDR_WIDTH-1:0] tx_buffer_addr,
  input  logic [DATA_WIDTH-1:0] tx_buffer_rd_data,
  output logic                  tx_req,
  input  logic                  tx_grant,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_eof,
  input  logic                  tx_ready
`ifdef GBE_CPU_TX_CTRL_FRAME_COUNT_EN
  ,
  output logic [31:0]           tx_frame_count
`endif
);
  localparam int          LW    = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  tx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_s;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   rd_done_q, rd_done_d;
  logic                   rd_vld_q, rd_last_q, rd_en, rd_last;
  logic [1:0]             occ;
  logic [2:0]             fill;
  logic                   pop;

  assign ready_s = sync_q[SYNC_STAGES-1];
  assign pop     = tx_valid & tx_ready;
  // Words the skid will hold after this edge; a read issued now lands one cycle later.
  assign fill    = 3'(occ) + 3'(rd_vld_q) - 3'(pop);
  assign rd_last = ({1'b0, addr_q} == len_q - LW'(1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rd_done_d = rd_done_q;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d    = '0;
        rd_done_d = 1'b0;
        if (ready_s) begin
          if (cpu_tx_size != '0) begin
            len_d   = (32'(cpu_tx_size) >= DEPTH) ? LW'(DEPTH) : LW'(cpu_tx_size);
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (tx_grant) begin
          rd_en   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        rd_en = !rd_done_q && (fill <= 3'd1);
        if (pop && tx_eof) state_d = DONE;
      end
      DONE: begin
        if (!ready_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      if (rd_last) rd_done_d = 1'b1;
      else         addr_d    = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
    if (!mac_tx_rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= SYNC_STAGES'({sync_q, cpu_tx_ready});
      addr_q    <= addr_d;
      len_q     <= len_d;
      rd_done_q <= rd_done_d;
      rd_vld_q  <= rd_en;
      rd_last_q <= rd_en & rd_last;
    end
  end

  gbe_tx_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_i      (mac_tx_clk),
    .rst_ni     (mac_tx_rst_n),
    .in_valid_i (rd_vld_q),
    .in_data_i  (tx_buffer_rd_data),
    .in_last_i  (rd_last_q),
    .out_ready_i(tx_ready),
    .out_valid_o(tx_valid),
    .out_data_o (tx_data),
    .out_last_o (tx_eof),
    .occ_o      (occ)
  );

  assign tx_buffer_addr = addr_q;
  assign tx_req         = (state_q == REQ) || (state_q == STREAM);
  assign cpu_tx_done    = (state_q == DONE);

`ifdef GBE_CPU_TX_CTRL_FRAME_COUNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
    if (!mac_tx_rst_n)      cnt_q <= '0;
    else if (pop && tx_eof) cnt_q <= cnt_q + 32'd1;
  end
  assign tx_frame_count = cnt_q;
`endif
endmodule

// File: tb/tb_gbe_cpu_tx_ctrl.sv
// Self-checking bench for gbe_cpu_tx_ctrl: table of frames, random frames, reset and stall corners.
module tb_gbe_cpu_tx_ctrl;
  import gbe_cpu_tx_pkg::*;
  localparam int SS = DEF_SYNC_STAGES;

  logic        mac_tx_clk = 1'b0;
  logic        mac_tx_rst_n = 1'b0;
  logic [11:0] cpu_tx_size = '0;
  logic        cpu_tx_ready = 1'b0;
  logic        cpu_tx_done;
  logic [7:0]  tx_buffer_addr;
  logic [63:0] tx_buffer_rd_data;
  logic        tx_req;
  logic        tx_grant = 1'b0;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_eof;
  logic        tx_ready = 1'b1;
`ifdef GBE_CPU_TX_CTRL_FRAME_COUNT_EN
  logic [31:0] tx_frame_count;
`endif

  gbe_cpu_tx_ctrl dut (
    .mac_tx_clk       (mac_tx_clk),
    .mac_tx_rst_n     (mac_tx_rst_n),
    .cpu_tx_size      (cpu_tx_size),
    .cpu_tx_ready     (cpu_tx_ready),
    .cpu_tx_done      (cpu_tx_done),
    .tx_buffer_addr   (tx_buffer_addr),
    .tx_buffer_rd_data(tx_buffer_rd_data),
    .tx_req           (tx_req),
    .tx_grant         (tx_grant),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_eof           (tx_eof),
    .tx_ready         (tx_ready)
`ifdef GBE_CPU_TX_CTRL_FRAME_COUNT_EN
    ,
    .tx_frame_count   (tx_frame_count)
`endif
  );

  always #5 mac_tx_clk = ~mac_tx_clk;

  // TX buffer model: 1-cycle read latency
  logic [63:0] mem [0:255];
  always @(posedge mac_tx_clk) tx_buffer_rd_data <= mem[tx_buffer_addr];

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int rdy_cnt = 0;
  bit [6:0] pat = 7'b1101001;  // 1,0,0,1,0,1,1 from bit 0

  typedef struct { int size; int gdelay; int mode; int exp_beats; } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_len(input int size);
    return (size > 256) ? 256 : size;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctrl"}, 64'({tx_req, tx_valid, tx_eof, cpu_tx_done}), 64'(0));
    chk({tag, "_data"}, tx_data, 64'(0));
    chk({tag, "_addr"}, 64'(tx_buffer_addr), 64'(0));
  endtask

  // downstream ready driver
  initial forever begin
    @(posedge mac_tx_clk); #1;
    case (rdy_mode)
      1:       tx_ready = pat[rdy_cnt % 7];
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
    rdy_cnt++;
  end

  // Called at a negedge with the DUT idle (or just released from reset with ready held).
  task automatic run_frame(input int size, input int gdelay, input int mode, input int exp_n,
                           input int rst_at, output bit aborted);
    int k, idx, lat;
    bit pstall, pe, seen;
    logic [63:0] pd;
    aborted = 1'b0;
    cpu_tx_size = 12'(size);
    cpu_tx_ready = 1'b1;
    rdy_mode = mode;
    rdy_cnt = 0;
    k = 0;
    do begin @(negedge mac_tx_clk); k++; end while (!tx_req && !cpu_tx_done && k < 40);
    chk("start_lat", 64'(k), 64'(SS + 1));
    if (exp_n == 0) begin
      chk("zero_done_noreq", 64'({tx_req, tx_valid, cpu_tx_done}), 64'(1));
    end else begin
      chk("req_only", 64'({tx_req, cpu_tx_done, tx_valid}), 64'(4));
      repeat (gdelay) @(negedge mac_tx_clk);
      chk("no_valid_pre_grant", 64'(tx_valid), 64'(0));
      tx_grant = 1'b1;
      idx = 0; lat = 0; seen = 0; pstall = 0; pe = 0; pd = '0;
      while (idx < exp_n && lat < exp_n * 30 + 50) begin
        @(negedge mac_tx_clk); lat++;
        if (!seen && tx_valid) begin
          chk("valid_lat", 64'(lat), 64'(2));
          seen = 1;
        end
        if (pstall) begin
          chk("stall_valid", 64'(tx_valid), 64'(1));
          chk("stall_data", tx_data, pd);
          chk("stall_eof", 64'(tx_eof), 64'(pe));
        end
        if (tx_valid && tx_ready) begin
          chk("data", tx_data, mem[idx]);
          chk("eof", 64'(tx_eof), 64'(idx == exp_n - 1));
          idx++;
          if (idx == rst_at) begin
            mac_tx_rst_n = 1'b0;
            #1;
            chk_rst("midframe_rst");
            tx_grant = 1'b0;
            aborted = 1'b1;
            return;
          end
        end
        pstall = tx_valid && !tx_ready;
        pd = tx_data;
        pe = tx_eof;
      end
      chk("beat_count", 64'(idx), 64'(exp_n));
      @(negedge mac_tx_clk);
      chk("done_after_eof", 64'({cpu_tx_done, tx_req, tx_valid}), 64'(4));
      chk("last_addr", 64'(tx_buffer_addr), 64'(exp_n - 1));
      tx_grant = 1'b0;
    end
    repeat (2) @(negedge mac_tx_clk);
    chk("done_hold", 64'({cpu_tx_done, tx_req}), 64'(2));
    cpu_tx_ready = 1'b0;
    cpu_tx_size = '0;
    k = 0;
    do begin @(negedge mac_tx_clk); k++; end while (cpu_tx_done && k < 40);
    chk("done_clear_lat", 64'(k), 64'(SS + 1));
  endtask

  initial begin
    bit ab;
    int sz;
    vecs[0] = '{4, 3, 0, 4};
    vecs[1] = '{8, 0, 1, 8};
    vecs[2] = '{0, 0, 0, 0};
    vecs[3] = '{'h300, 1, 0, 256};
    vecs[4] = '{1, 2, 2, 1};
    vecs[5] = '{2, 0, 1, 2};
    vecs[6] = '{256, 0, 2, 256};
    vecs[7] = '{257, 4, 2, 256};
    vecs[8] = '{'hFFF, 0, 1, 256};
    fill_mem();
    repeat (3) @(negedge mac_tx_clk);
    chk_rst("reset_state");
    mac_tx_rst_n = 1'b1;
    @(negedge mac_tx_clk);

    foreach (vecs[i]) run_frame(vecs[i].size, vecs[i].gdelay, vecs[i].mode, vecs[i].exp_beats, -1, ab);

    for (int r = 0; r < 6; r++) begin
      fill_mem();
      sz = int'($urandom_range(1, 300));
      run_frame(sz, int'($urandom_range(0, 4)), 2, model_len(sz), -1, ab);
    end

    // reset at beat 5, ready held high, fresh frame from word 0
    run_frame(16, 1, 0, 16, 5, ab);
    chk("rst_aborted", 64'(ab), 64'(1));
    repeat (3) @(negedge mac_tx_clk);
    mac_tx_rst_n = 1'b1;
    run_frame(16, 0, 1, 16, -1, ab);

`ifdef GBE_CPU_TX_CTRL_FRAME_COUNT_EN
    mac_tx_rst_n = 1'b0;
    @(negedge mac_tx_clk);
    chk("fc_reset", 64'(tx_frame_count), 64'(0));
    mac_tx_rst_n = 1'b1;
    @(negedge mac_tx_clk);
    run_frame(1, 0, 0, 1, -1, ab);
    run_frame(2, 1, 0, 2, -1, ab);
    run_frame(0, 0, 0, 0, -1, ab);
    chk("frame_count", 64'(tx_frame_count), 64'(2));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
